demux4_8_stream: RTL and testbench

- 1-to-4 byte-stream demultiplexer. It is the inverse of the 4:1 8-bit select mux.
- One input stream carries a 2-bit channel select. Each accepted byte is routed to one of four output channels.
- Each output channel has its own small FIFO and a valid/ready handshake, so a stalled channel does not block traffic to the others once its byte has been accepted.
- Sits between a single byte producer and four independent byte consumers in the datapath.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_chan_fifo.sv | 54 +++++
 rtl/demux4_8_stream.sv | 52 +++++
 tb/tb_demux4_8_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and sizing helpers for the 1-to-4 byte-stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    // One extra pointer bit distinguishes full from empty when the low bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(2);

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel synchronous FIFO; head reads as zero whenever the FIFO is empty.
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointers wrap naturally modulo 2*DEPTH through their own width.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/demux4_8_stream.sv
// 1-to-4 byte-stream demultiplexer: select decode, ready mux and four channel FIFOs.
module demux4_8_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [WIDTH-1:0]             i_in_data,
    input  logic [1:0]                   i_in_sel,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    output logic [NUM_CH-1:0][WIDTH-1:0] o_out_data,
    output logic [NUM_CH-1:0]            o_out_valid,
    input  logic [NUM_CH-1:0]            i_out_ready,
    output logic [NUM_CH-1:0]            o_ch_full,
    output logic [NUM_CH-1:0]            o_ch_empty
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic              w_accept;

    // Ready looks only at registered full flags, never at the consumers.
    assign o_in_ready = !i_reset && !w_full[i_in_sel];
    assign w_accept   = i_in_valid && o_in_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_push[g] = w_accept && (i_in_sel == ch_sel_t'(g));

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (w_push[g]),
            .i_data  (i_in_data),
            .i_pop   (i_out_ready[g]),
            .o_data  (o_out_data[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    assign o_out_valid = ~w_empty;
    assign o_ch_full   = w_full;
    assign o_ch_empty  = w_empty;

endmodule

// File: tb/tb_demux4_8_stream.sv
// Directed bench for demux4_8_stream with a per-channel expected-data scoreboard.
module tb_demux4_8_stream;

    logic            clk;
    logic            reset;
    logic [7:0]      in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [3:0]      ch_full;
    logic [3:0]      ch_empty;

    int total = 0;
    int bad   = 0;
    int rcv2  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    demux4_8_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_data   (in_data),
        .i_in_sel    (in_sel),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_ch_full   (ch_full),
        .o_ch_empty  (ch_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        case (ch)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_exp(input int ch, output logic [7:0] d);
        case (ch)
            0: d = q0.pop_front();
            1: d = q1.pop_front();
            2: d = q2.pop_front();
            default: d = q3.pop_front();
        endcase
    endtask

    // Sample at the falling edge what the next rising edge will transfer, then advance.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (qsize(c) == 0) begin
                        chk($sformatf("sb_unexpected_ch%0d", c), {24'd0, out_data[c]}, 32'hDEAD);
                    end else begin
                        pop_exp(c, e);
                        chk($sformatf("sb_data_ch%0d", c), {24'd0, out_data[c]}, {24'd0, e});
                        if (c == 2) rcv2++;
                    end
                end
            end
            if (in_valid && in_ready) push_exp(int'(in_sel), in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_empty", {28'd0, ch_empty}, 32'hF);
        chk("rst_full", {28'd0, ch_full}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ready", {31'd0, in_ready}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, in_ready}, 32'h1);

        // Routing: one byte per channel on consecutive cycles, one-cycle latency.
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data = 8'h00; in_sel = 2'd0; tick();
        chk("route0_valid", {28'd0, out_valid}, 32'h1);
        chk("route0_data", {24'd0, out_data[0]}, 32'h00);
        in_data = 8'h55; in_sel = 2'd1; tick();
        chk("route1_valid", {28'd0, out_valid}, 32'h2);
        chk("route1_data", {24'd0, out_data[1]}, 32'h55);
        in_data = 8'hAA; in_sel = 2'd2; tick();
        chk("route2_valid", {28'd0, out_valid}, 32'h4);
        chk("route2_data", {24'd0, out_data[2]}, 32'hAA);
        in_data = 8'hFF; in_sel = 2'd3; tick();
        chk("route3_valid", {28'd0, out_valid}, 32'h8);
        chk("route3_data", {24'd0, out_data[3]}, 32'hFF);
        in_valid = 1'b0; tick();
        chk("route_idle", {28'd0, out_valid}, 32'h0);

        // Backpressure on ch1 until full.
        out_ready = 4'b1101;
        in_valid  = 1'b1; in_sel = 2'd1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        chk("bp_full1", {31'd0, ch_full[1]}, 32'h1);
        in_data = 8'h33;
        #1;
        chk("bp_ready_low", {31'd0, in_ready}, 32'h0);
        tick(); tick();
        chk("bp_head", {24'd0, out_data[1]}, 32'h11);
        chk("bp_still_full", {31'd0, ch_full[1]}, 32'h1);

        // Independence: ch3 still accepts while ch1 is stalled.
        in_data = 8'hA5; in_sel = 2'd3;
        #1;
        chk("ind_ready", {31'd0, in_ready}, 32'h1);
        tick();
        chk("ind_valid3", {31'd0, out_valid[3]}, 32'h1);
        chk("ind_data3", {24'd0, out_data[3]}, 32'hA5);

        // Release ch1: full refuses the push on the pop cycle, then drains in order.
        in_data = 8'h33; in_sel = 2'd1;
        out_ready = 4'b1111;
        tick();
        chk("bp_drain_head", {24'd0, out_data[1]}, 32'h22);
        chk("bp_drain_full", {31'd0, ch_full[1]}, 32'h0);
        tick();
        chk("bp_last_head", {24'd0, out_data[1]}, 32'h33);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", {28'd0, ch_empty}, 32'hF);

        // Simultaneous push and pop on ch0 with one entry held.
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01; tick();
        in_valid = 1'b0; tick();
        chk("pp_hold", {24'd0, out_data[0]}, 32'h01);
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'h02; tick();
        chk("pp_head", {24'd0, out_data[0]}, 32'h02);
        chk("pp_notfull", {31'd0, ch_full[0]}, 32'h0);
        chk("pp_valid", {31'd0, out_valid[0]}, 32'h1);
        in_valid = 1'b0; tick();
        chk("pp_empty", {31'd0, ch_empty[0]}, 32'h1);

        // Pointer wrap: ten bytes to ch2 with its consumer toggling every cycle.
        rcv2 = 0;
        out_ready = 4'b1011;
        in_sel = 2'd2;
        for (int k = 0; k < 10; k++) begin
            logic acc;
            int   guard;
            in_valid = 1'b1;
            in_data  = 8'(k);
            acc      = 1'b0;
            guard    = 0;
            while (!acc && guard < 20) begin
                out_ready[2] = ~out_ready[2];
                #1;
                acc = in_ready;
                tick();
                guard++;
            end
            if (!acc) chk("wrap_accept_timeout", 32'(k), 32'hFFFF);
        end
        in_valid = 1'b0;
        for (int g = 0; g < 40 && !ch_empty[2]; g++) begin
            out_ready[2] = ~out_ready[2];
            tick();
        end
        chk("wrap_empty", {31'd0, ch_empty[2]}, 32'h1);
        chk("wrap_count", 32'(rcv2), 32'd10);

        // Reset with bytes buffered in ch0 and ch2.
        out_ready = 4'b0000;
        in_valid = 1'b1;
        in_sel = 2'd0; in_data = 8'h3C; tick();
        in_sel = 2'd2; in_data = 8'h5A; tick();
        chk("mid_valid", {28'd0, out_valid}, 32'h5);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {28'd0, out_valid}, 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_empty", {28'd0, ch_empty}, 32'hF);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'h0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        in_sel = 2'd1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'h1);
        chk("post_rst_empty", {28'd0, ch_empty}, 32'hF);

        for (int c = 0; c < 4; c++)
            chk($sformatf("sb_left_ch%0d", c), 32'(qsize(c)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
